load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator for the byte-lane data memory. It accepts one load/store from the pipeline and drives address, wr/rd masks and write data.
//  It captures the memory's registered read data one cycle later and returns the result with a ready/valid handshake.
//  Misaligned accesses are either split into byte beats or trapped, selected by parameter.
//  Sits between the execute stage and the data memory.
// PARAMETERS
//  SPLIT_MISALIGNED  1         1: split misaligned half/word into byte beats; 0: respond err=1, no memory access
//  ADDR_LIMIT        32'h1000  any accessed byte address >= limit -> err=3, no memory access
// PORTS
//  i_clk            in   1   clock, rising edge
//  i_reset_n        in   1   async active-low reset
//  i_req_valid      in   1   request valid
//  o_req_ready      out  1   (state==IDLE) && i_reset_n
//  i_req_op         in   4   [3]=store, [2]=unsigned load, [1:0]=size 0:B 1:H 2:W 3:illegal
//  i_req_addr       in   32  byte address
//  i_req_wdata      in   32  store data, right-justified
//  i_req_tag        in   5   destination register tag, echoed
//  o_resp_valid     out  1   response valid, held until accepted
//  i_resp_ready     in   1   response accepted
//  o_resp_data      out  32  load result, extended; 0 for stores and errors
//  o_resp_tag       out  5   latched i_req_tag
//  o_resp_err       out  2   0 ok, 1 misaligned (trap mode), 2 memory-flagged, 3 illegal size/out of range
//  o_mem_address    out  32  memory byte address
//  o_mem_wr_data    out  32  memory write data
//  o_mem_wr_mask    out  2   0 N, 1 B, 2 H, 3 W
//  o_mem_rd_mask    out  3   0 W, 1 HZ, 2 BZ, 3 HE, 4 BE; never 5-7
//  i_mem_rd_data    in   32  memory read data, valid 1 cycle after the address edge
//  i_mem_err_misal  in   1   memory misaligned flag, same timing as rd_data
//  i_mem_err_rdmask in   1   memory invalid read-mask flag, same timing
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, CAPTURE, RESP.
//  - Reset (async): state=IDLE; all response regs and o_mem_address/wr_data = 0.
//    - o_mem_wr_mask=N and o_mem_rd_mask=W immediately.
//  - o_mem_* is decoded only from registered state; there is no combinational path from i_req_*.
//  - Outside ISSUE: wr_mask=N, rd_mask=W.
//  - Accept edge: i_req_valid && o_req_ready.
//    - Latch op, addr, wdata and tag; clear the assembly buffer.
//    - Classify: aligned (B; H with a[0]=0; W with a[1:0]=0) -> 1 beat, native masks.
//    - Misaligned H -> 2 byte beats; misaligned W -> 4 byte beats.
//    - Illegal size, or addr+bytes-1 >= ADDR_LIMIT -> RESP, err=3.
//    - Misaligned with SPLIT_MISALIGNED=0 -> RESP, err=1.
//    - Otherwise -> ISSUE, beat=0.
//  - ISSUE, beat k: address = addr+k (32-bit wrap) for split accesses, addr otherwise.
//    - Aligned: store W/H/B with wdata unchanged (memory takes the low bits); load rd_mask W, HZ/HE or BZ/BE per op[2].
//    - Split: store wr_mask B, wr_data = {24'b0, wdata[8k+:8]}; load rd_mask BZ.
//    - Next state -> CAPTURE. The memory commits the write at the edge ending ISSUE.
//  - CAPTURE: sample i_mem_rd_data and the error flags at the end of the cycle.
//    - Aligned load: result = rd_data.
//    - Split load: buf[8k+:8] = rd_data[7:0].
//    - Any memory flag sets sticky err=2.
//    - Next state -> ISSUE with k+1 if beats remain, else RESP.
//  - Split-load finish: buf is extended to 32 bits per size and op[2], then latched into o_resp_data on entering RESP.
//  - RESP: o_resp_valid=1 with data, tag and err stable. Exit to IDLE on i_resp_ready.
//  - Back-to-back requests: the next accept is in the IDLE cycle after RESP is accepted.
//  - Latency from the accept edge to the first o_resp_valid cycle:
//    - N-beat access: 2N+1 cycles.
//    - Trapped/illegal request: 1 cycle.
//  - Errors:
//    - err=2 still completes all beats; writes already issued are not undone.
//    - err=1/3 drive no memory write.
//  - Reset mid-operation: returns to IDLE at once and wr_mask drops to N before the next edge, so no write is committed.
//    - Earlier beats of a split store stay written; the response is lost.
// TESTING
//  - Store W 0x11223344 @0x20, then load W @0x20 -> store resp cycle 3, err 0; load resp cycle 3, data 0x11223344.
//  - Store W 0x55667788 @0x24; load W @0x21 (SPLIT=1):
//    - 4 BZ beats at 0x21..0x24; resp cycle 9, data 0x88112233.
//  - Load H @0x23:
//    - signed -> 0xFFFF8811;
//    - unsigned -> 0x00008811;
//    - load BE @0x24 -> 0xFFFFFF88.
//  - Store H 0xABCD @0x27 -> beats wr_mask B:
//    - wr_data 0xCD @0x27, then 0xAB @0x28;
//    - load W @0x24 -> 0xCD667788.
//  - SPLIT=0: load W @0x22 -> resp cycle 1, err 1, wr_mask never nonzero. Load W @0xFFE -> err 3.
//  - Backpressure and reset:
//    - hold i_resp_ready=0 for 3 cycles -> outputs stable, o_req_ready=0;
//    - reset during store ISSUE -> no write (readback unchanged), all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for a registered byte-lane data memory; splits or traps misaligned accesses.
// Latency: accept -> o_resp_valid in 2N+1 cycles for an N-beat access, 1 cycle for trapped/illegal requests.
// Backpressure: one request in flight; o_req_ready only in IDLE, response held in RESP until i_resp_ready.
//
// Ports:
//   i_clk, i_reset_n                 clock (rising edge), async active-low reset
//   i_req_*  / o_req_ready           request from execute: op {store, unsigned, size}, addr, wdata, tag
//   o_resp_* / i_resp_ready          response: extended load data, echoed tag, error code
//   o_mem_*                          memory address, write data, write mask (N/B/H/W), read mask (W/HZ/BZ/HE/BE)
//   i_mem_rd_data, i_mem_err_*       registered memory read data and error flags (one cycle after address)
module load_store_unit #(
    parameter bit          SPLIT_MISALIGNED = 1'b1,
    parameter logic [31:0] ADDR_LIMIT       = 32'h1000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_req_op,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [4:0]  i_req_tag,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_data,
    output logic [4:0]  o_resp_tag,
    output logic [1:0]  o_resp_err,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wr_data,
    output logic [1:0]  o_mem_wr_mask,
    output logic [2:0]  o_mem_rd_mask,
    input  logic [31:0] i_mem_rd_data,
    input  logic        i_mem_err_misal,
    input  logic        i_mem_err_rdmask
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // Memory mask encodings
    localparam logic [1:0] WR_N  = 2'd0;
    localparam logic [1:0] WR_B  = 2'd1;
    localparam logic [1:0] WR_H  = 2'd2;
    localparam logic [1:0] WR_W  = 2'd3;
    localparam logic [2:0] RD_W  = 3'd0;
    localparam logic [2:0] RD_HZ = 3'd1;
    localparam logic [2:0] RD_BZ = 3'd2;
    localparam logic [2:0] RD_HE = 3'd3;
    localparam logic [2:0] RD_BE = 3'd4;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  tag_q, tag_d;
    logic        split_q, split_d;
    logic [1:0]  beat_q, beat_d;
    logic [1:0]  last_beat_q, last_beat_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [1:0]  resp_err_q, resp_err_d;

    // Request classification
    logic        req_acc;
    logic [1:0]  req_size;
    logic [32:0] req_last_byte;
    logic        req_illegal;
    logic        req_range_err;
    logic        req_misal;

    // Capture-side helpers
    logic [31:0] buf_fill;
    logic [31:0] buf_ext;
    logic [31:0] load_result;
    logic        mem_flag;

    assign req_acc = i_req_valid && o_req_ready;

    always_comb begin
        req_size    = i_req_op[1:0];
        req_illegal = (req_size == 2'd3);
        // 33-bit sum so an access that wraps past 0xFFFFFFFF still counts as out of range
        case (req_size)
            2'd1:    req_last_byte = {1'b0, i_req_addr} + 33'd1;
            2'd2:    req_last_byte = {1'b0, i_req_addr} + 33'd3;
            default: req_last_byte = {1'b0, i_req_addr};
        endcase
        req_range_err = (req_last_byte >= {1'b0, ADDR_LIMIT});
        req_misal     = ((req_size == 2'd1) && i_req_addr[0]) ||
                        ((req_size == 2'd2) && (i_req_addr[1:0] != 2'b00));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_acc) begin
                    if (req_illegal || req_range_err || (req_misal && !SPLIT_MISALIGNED)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = (beat_q == last_beat_q) ? S_RESP : S_ISSUE;
            S_RESP:    if (i_resp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Split-load assembly: merge the current byte, then extend per size/signedness
    always_comb begin
        buf_fill = buf_q;
        buf_fill[{beat_q, 3'b000} +: 8] = i_mem_rd_data[7:0];
        case (op_q[1:0])
            2'd0:    buf_ext = op_q[2] ? {24'd0, buf_fill[7:0]}  : {{24{buf_fill[7]}}, buf_fill[7:0]};
            2'd1:    buf_ext = op_q[2] ? {16'd0, buf_fill[15:0]} : {{16{buf_fill[15]}}, buf_fill[15:0]};
            default: buf_ext = buf_fill;
        endcase
        // Aligned loads are already extended by the memory via the read mask
        load_result = split_q ? buf_ext : i_mem_rd_data;
        mem_flag    = i_mem_err_misal || i_mem_err_rdmask;
    end

    // Datapath next values
    always_comb begin
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tag_d       = tag_q;
        split_d     = split_q;
        beat_d      = beat_q;
        last_beat_d = last_beat_q;
        buf_d       = buf_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_acc) begin
                    op_d        = i_req_op;
                    addr_d      = i_req_addr;
                    wdata_d     = i_req_wdata;
                    tag_d       = i_req_tag;
                    split_d     = req_misal;
                    beat_d      = 2'd0;
                    last_beat_d = req_misal ? ((req_size == 2'd1) ? 2'd1 : 2'd3) : 2'd0;
                    buf_d       = 32'd0;
                    resp_data_d = 32'd0;
                    if (req_illegal || req_range_err) begin
                        resp_err_d = 2'd3;
                    end else if (req_misal && !SPLIT_MISALIGNED) begin
                        resp_err_d = 2'd1;
                    end else begin
                        resp_err_d = 2'd0;
                    end
                end
            end
            S_CAPTURE: begin
                if (split_q) buf_d = buf_fill;
                // Sticky: a flag on any beat marks the whole access, remaining beats still run
                if (mem_flag) resp_err_d = 2'd2;
                if (beat_q != last_beat_q) begin
                    beat_d = beat_q + 2'd1;
                end else begin
                    resp_data_d = (op_q[3] || mem_flag || (resp_err_q == 2'd2)) ? 32'd0 : load_result;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            tag_q       <= 5'd0;
            split_q     <= 1'b0;
            beat_q      <= 2'd0;
            last_beat_q <= 2'd0;
            buf_q       <= 32'd0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag_q       <= tag_d;
            split_q     <= split_d;
            beat_q      <= beat_d;
            last_beat_q <= last_beat_d;
            buf_q       <= buf_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Outputs: memory side is decoded only from registers, so a reset drops the masks at once
    always_comb begin
        o_req_ready   = (state_q == S_IDLE) && i_reset_n;
        o_resp_valid  = (state_q == S_RESP);
        o_resp_data   = resp_data_q;
        o_resp_tag    = tag_q;
        o_resp_err    = resp_err_q;
        o_mem_address = split_q ? (addr_q + {30'd0, beat_q}) : addr_q;
        o_mem_wr_data = split_q ? {24'd0, wdata_q[{beat_q, 3'b000} +: 8]} : wdata_q;
        o_mem_wr_mask = WR_N;
        o_mem_rd_mask = RD_W;
        if (state_q == S_ISSUE) begin
            if (op_q[3]) begin
                if (split_q) begin
                    o_mem_wr_mask = WR_B;
                end else begin
                    case (op_q[1:0])
                        2'd0:    o_mem_wr_mask = WR_B;
                        2'd1:    o_mem_wr_mask = WR_H;
                        2'd2:    o_mem_wr_mask = WR_W;
                        default: o_mem_wr_mask = WR_N;
                    endcase
                end
            end else begin
                if (split_q) begin
                    o_mem_rd_mask = RD_BZ;
                end else begin
                    case (op_q[1:0])
                        2'd0:    o_mem_rd_mask = op_q[2] ? RD_BZ : RD_BE;
                        2'd1:    o_mem_rd_mask = op_q[2] ? RD_HZ : RD_HE;
                        default: o_mem_rd_mask = RD_W;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte-addressed memory model, reference model, directed + random requests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid1 = 1'b0, req_valid0 = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [4:0]  req_tag = 5'd0;
    logic        resp_ready = 1'b0;
    logic        inj = 1'b0;
    bit          use0 = 1'b0;

    logic        rdy1, rvld1, rdy0, rvld0;
    logic [31:0] rdata1, rdata0, maddr1, maddr0, mwd1, mwd0;
    logic [4:0]  rtag1, rtag0;
    logic [1:0]  rerr1, rerr0, mwm1, mwm0;
    logic [2:0]  mrm1, mrm0;
    logic [31:0] mem_rd_data = 32'd0;
    logic        mem_err_rdmask = 1'b0;

    load_store_unit #(.SPLIT_MISALIGNED(1'b1), .ADDR_LIMIT(32'h1000)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid1), .o_req_ready(rdy1), .i_req_op(req_op), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_tag(req_tag),
        .o_resp_valid(rvld1), .i_resp_ready(resp_ready), .o_resp_data(rdata1), .o_resp_tag(rtag1),
        .o_resp_err(rerr1), .o_mem_address(maddr1), .o_mem_wr_data(mwd1), .o_mem_wr_mask(mwm1),
        .o_mem_rd_mask(mrm1), .i_mem_rd_data(mem_rd_data), .i_mem_err_misal(1'b0),
        .i_mem_err_rdmask(mem_err_rdmask)
    );

    load_store_unit #(.SPLIT_MISALIGNED(1'b0), .ADDR_LIMIT(32'h1000)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid0), .o_req_ready(rdy0), .i_req_op(req_op), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_tag(req_tag),
        .o_resp_valid(rvld0), .i_resp_ready(resp_ready), .o_resp_data(rdata0), .o_resp_tag(rtag0),
        .o_resp_err(rerr0), .o_mem_address(maddr0), .o_mem_wr_data(mwd0), .o_mem_wr_mask(mwm0),
        .o_mem_rd_mask(mrm0), .i_mem_rd_data(32'd0), .i_mem_err_misal(1'b0),
        .i_mem_err_rdmask(1'b0)
    );

    wire        o_rdy   = use0 ? rdy0 : rdy1;
    wire        o_rvld  = use0 ? rvld0 : rvld1;
    wire [31:0] o_rdata = use0 ? rdata0 : rdata1;
    wire [1:0]  o_rerr  = use0 ? rerr0 : rerr1;
    wire [4:0]  o_rtag  = use0 ? rtag0 : rtag1;

    int total = 0;
    int bad = 0;

    // Memory seen by the DUT, and the reference model's own copy of the byte space
    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] waddr_q[$], wdat_q[$], raddr_q[$];
    logic [1:0]  wmask_q[$];
    logic [2:0]  rmask_q[$];
    bit          dut0_wrote = 1'b0;

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] m);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a[11:0]];
        b1 = mem[a[11:0] + 12'd1];
        b2 = mem[a[11:0] + 12'd2];
        b3 = mem[a[11:0] + 12'd3];
        case (m)
            3'd0:    return {b3, b2, b1, b0};
            3'd1:    return {16'd0, b1, b0};
            3'd2:    return {24'd0, b0};
            3'd3:    return {{16{b1[7]}}, b1, b0};
            3'd4:    return {{24{b0[7]}}, b0};
            default: return 32'hxxxxxxxx;
        endcase
    endfunction

    always @(posedge clk) begin
        mem_rd_data    <= mem_read(maddr1, mrm1);
        mem_err_rdmask <= inj;
        if (mrm1 != 3'd0) begin
            raddr_q.push_back(maddr1);
            rmask_q.push_back(mrm1);
        end
        if (mwm1 != 2'd0) begin
            mem[maddr1[11:0]] <= mwd1[7:0];
            if (mwm1 >= 2'd2) mem[maddr1[11:0] + 12'd1] <= mwd1[15:8];
            if (mwm1 == 2'd3) begin
                mem[maddr1[11:0] + 12'd2] <= mwd1[23:16];
                mem[maddr1[11:0] + 12'd3] <= mwd1[31:24];
            end
            waddr_q.push_back(maddr1);
            wdat_q.push_back(mwd1);
            wmask_q.push_back(mwm1);
        end
        if (mwm0 != 2'd0) dut0_wrote <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Reference model: outcome of one request from the access rules, updating ref_mem for stores
    task automatic model(input bit split, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit inject,
                         output logic [31:0] edata, output logic [1:0] eerr, output int elat);
        int n;
        longint last;
        logic [31:0] val;
        edata = 32'd0;
        eerr  = 2'd0;
        elat  = 1;
        n = 1 << op[1:0];
        last = longint'(addr) + n - 1;
        if (op[1:0] == 2'd3 || last >= 64'h1000) begin
            eerr = 2'd3;
            return;
        end
        if ((addr % n) != 0 && !split) begin
            eerr = 2'd1;
            return;
        end
        elat = ((addr % n) != 0) ? 2 * n + 1 : 3;
        if (op[3]) begin
            for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            val = 32'd0;
            for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[addr + i];
            if (n == 1 && !op[2]) val = {{24{val[7]}}, val[7:0]};
            if (n == 2 && !op[2]) val = {{16{val[15]}}, val[15:0]};
            edata = val;
        end
        if (inject) begin
            eerr  = 2'd2;
            edata = 32'd0;
        end
    endtask

    // One request: model it, drive it, check response and latency, hold off acceptance for 'hold' cycles
    task automatic run(input bit which0, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] tag, input int hold,
                       input bit inject, input string name, output logic [31:0] obs_data);
        logic [31:0] edata;
        logic [1:0]  eerr;
        int          elat, lat, guard;
        model(!which0, op, addr, wdata, inject, edata, eerr, elat);
        obs_data = 32'd0;
        use0 = which0;
        @(negedge clk);
        inj = inject;
        req_op = op; req_addr = addr; req_wdata = wdata; req_tag = tag;
        if (which0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
        guard = 0;
        while (!o_rdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!o_rdy) begin
            check({name, ".accept_timeout"}, 32'd0, 32'd1);
            req_valid0 = 1'b0; req_valid1 = 1'b0; inj = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid0 = 1'b0; req_valid1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_rvld && lat < 60);
        check({name, ".lat"}, lat, elat);
        if (!o_rvld) begin
            inj = 1'b0;
            return;
        end
        obs_data = o_rdata;
        check({name, ".data"}, o_rdata, edata);
        check({name, ".err"}, o_rerr, eerr);
        check({name, ".tag"}, o_rtag, tag);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, ".hold_vld"}, o_rvld, 1'b1);
            check({name, ".hold_rdy"}, o_rdy, 1'b0);
            check({name, ".hold_data"}, o_rdata, edata);
            check({name, ".hold_err"}, o_rerr, eerr);
            check({name, ".hold_tag"}, o_rtag, tag);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        inj = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  rop;
        logic [31:0] raddr;
        int          sel;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.req_ready", rdy1, 1'b0);
        check("rst.resp_valid", rvld1, 1'b0);
        check("rst.wr_mask", mwm1, 2'd0);
        check("rst.rd_mask", mrm1, 3'd0);
        check("rst.address", maddr1, 32'd0);
        check("rst.wr_data", mwd1, 32'd0);
        check("rst.resp_data", rdata1, 32'd0);
        check("rst.resp_tag", rtag1, 5'd0);
        check("rst.resp_err", rerr1, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.req_ready", rdy1, 1'b1);

        // Aligned word store/load
        run(1'b0, 4'b1010, 32'h20, 32'h11223344, 5'd1, 0, 1'b0, "st_w20", d);
        run(1'b0, 4'b0010, 32'h20, 32'h0, 5'd2, 0, 1'b0, "ld_w20", d);
        check("ld_w20.const", d, 32'h11223344);

        // Split word load across a word boundary
        run(1'b0, 4'b1010, 32'h24, 32'h55667788, 5'd3, 0, 1'b0, "st_w24", d);
        raddr_q.delete(); rmask_q.delete();
        run(1'b0, 4'b0010, 32'h21, 32'h0, 5'd4, 0, 1'b0, "ld_w21", d);
        check("ld_w21.const", d, 32'h88112233);
        check("ld_w21.beats", raddr_q.size(), 32'd4);
        if (raddr_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("ld_w21.beat%0d_addr", i), raddr_q[i], 32'h21 + i);
                check($sformatf("ld_w21.beat%0d_mask", i), rmask_q[i], 3'd2);
            end
        end

        // Split halfword loads and a signed byte load
        run(1'b0, 4'b0001, 32'h23, 32'h0, 5'd5, 0, 1'b0, "ld_h23s", d);
        check("ld_h23s.const", d, 32'hFFFF8811);
        run(1'b0, 4'b0101, 32'h23, 32'h0, 5'd6, 0, 1'b0, "ld_h23u", d);
        check("ld_h23u.const", d, 32'h00008811);
        run(1'b0, 4'b0000, 32'h24, 32'h0, 5'd7, 0, 1'b0, "ld_b24s", d);
        check("ld_b24s.const", d, 32'hFFFFFF88);

        // Split halfword store
        waddr_q.delete(); wdat_q.delete(); wmask_q.delete();
        run(1'b0, 4'b1001, 32'h27, 32'h0000ABCD, 5'd8, 0, 1'b0, "st_h27", d);
        check("st_h27.writes", waddr_q.size(), 32'd2);
        if (waddr_q.size() == 2) begin
            check("st_h27.w0_addr", waddr_q[0], 32'h27);
            check("st_h27.w0_data", wdat_q[0], 32'hCD);
            check("st_h27.w0_mask", wmask_q[0], 2'd1);
            check("st_h27.w1_addr", waddr_q[1], 32'h28);
            check("st_h27.w1_data", wdat_q[1], 32'hAB);
            check("st_h27.w1_mask", wmask_q[1], 2'd1);
        end
        run(1'b0, 4'b0010, 32'h24, 32'h0, 5'd9, 0, 1'b0, "ld_w24", d);
        check("ld_w24.const", d, 32'hCD667788);

        // Response backpressure
        run(1'b0, 4'b0010, 32'h20, 32'h0, 5'd10, 3, 1'b0, "bp_ld", d);

        // Trap mode, illegal size, range limit
        run(1'b1, 4'b0010, 32'h22, 32'h0, 5'd11, 0, 1'b0, "t0_ld_w22", d);
        run(1'b1, 4'b1010, 32'h22, 32'hFFFFFFFF, 5'd12, 1, 1'b0, "t0_st_w22", d);
        run(1'b1, 4'b0010, 32'hFFE, 32'h0, 5'd13, 0, 1'b0, "t0_ld_wffe", d);
        check("t0.no_write", dut0_wrote, 1'b0);
        run(1'b0, 4'b1011, 32'h20, 32'h0, 5'd14, 0, 1'b0, "ill_size", d);
        run(1'b0, 4'b0000, 32'hFFF, 32'h0, 5'd15, 0, 1'b0, "b_fff", d);
        run(1'b0, 4'b0000, 32'h1000, 32'h0, 5'd16, 0, 1'b0, "b_1000", d);

        // Memory-flagged error still completes all beats of a split store
        run(1'b0, 4'b1010, 32'h31, 32'hA1B2C3D4, 5'd17, 0, 1'b1, "inj_st", d);
        run(1'b0, 4'b0010, 32'h31, 32'h0, 5'd18, 0, 1'b0, "inj_rd", d);

        // Reset during a store's ISSUE cycle
        use0 = 1'b0;
        @(negedge clk);
        req_op = 4'b1010; req_addr = 32'h20; req_wdata = 32'hDEADBEEF; req_tag = 5'd19;
        req_valid1 = 1'b1;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        check("rst_mid.wr_mask_before", mwm1, 2'd3);
        rst_n = 1'b0;
        #1;
        check("rst_mid.wr_mask", mwm1, 2'd0);
        check("rst_mid.rd_mask", mrm1, 3'd0);
        check("rst_mid.address", maddr1, 32'd0);
        check("rst_mid.wr_data", mwd1, 32'd0);
        check("rst_mid.resp_valid", rvld1, 1'b0);
        check("rst_mid.req_ready", rdy1, 1'b0);
        check("rst_mid.resp_data", rdata1, 32'd0);
        check("rst_mid.resp_tag", rtag1, 5'd0);
        check("rst_mid.resp_err", rerr1, 2'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 4'b0010, 32'h20, 32'h0, 5'd20, 0, 1'b0, "rst_mid.readback", d);
        check("rst_mid.readback_const", d, 32'h11223344);

        // Random traffic against the reference model
        for (int it = 0; it < 60; it++) begin
            rop[3]   = 1'($urandom_range(0, 1));
            rop[2]   = 1'($urandom_range(0, 1));
            rop[1:0] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      raddr = 32'($urandom_range(0, 63));
            else if (sel < 9) raddr = 32'($urandom_range(32'hFF8, 32'h1003));
            else              raddr = $urandom;
            run(1'b0, rop, raddr, $urandom, 5'($urandom_range(0, 31)),
                int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0),
                $sformatf("rnd%0d", it), d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
